// File: rtl/mdu.sv
// mdu -- multiply/divide unit for the execute stage of the pipelined MIPS
// datapath. Runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations,
// holds the architectural HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   Start   launch the multi-cycle operation selected by MDUOp
//   MDUOp   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO,
//           7 MTHI, 8 MTLO; 9-15 behave as NONE
//   SrcA    operand rs
//   SrcB    operand rt (from the ALU source mux)
//   Busy    registered, high while a multiply/divide is in flight
//   HI, LO  architectural HI/LO registers
//   MDUOut  combinational read port: HI on MFHI, LO on MFLO, else 0
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_t;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] resHI;
  logic [31:0] resLO;
  logic        skip_wr;

  logic        is_mul;
  logic        is_div;
  logic        launch;
  logic        div_zero;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] res_hi;
  logic        [31:0] res_lo;

  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  assign is_mul   = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign is_div   = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign launch   = Start && (is_mul || is_div);
  assign div_zero = (SrcB == '0);

  // One unsigned divider serves both DIV and DIVU: signed operands are
  // reduced to magnitudes and the signs reapplied afterwards. A zero
  // divisor is replaced by 1 only to keep the divider well defined; that
  // result is never committed.
  always_comb begin
    neg_a  = (MDUOp == OP_DIV) && SrcA[31];
    neg_b  = (MDUOp == OP_DIV) && SrcB[31];
    mag_a  = neg_a ? (~SrcA + 32'd1) : SrcA;
    mag_b  = div_zero ? 32'd1 : (neg_b ? (~SrcB + 32'd1) : SrcB);
    q_mag  = mag_a / mag_b;
    r_mag  = mag_a % mag_b;

    prod_s = $signed({{32{SrcA[31]}}, SrcA}) * $signed({{32{SrcB[31]}}, SrcB});
    prod_u = {32'd0, SrcA} * {32'd0, SrcB};

    res_hi = '0;
    res_lo = '0;
    case (MDUOp)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        // Quotient truncates toward zero; remainder takes the dividend sign.
        res_lo = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        res_hi = neg_a ? (~r_mag + 32'd1) : r_mag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      cnt     <= '0;
      resHI   <= '0;
      resLO   <= '0;
      skip_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            resHI   <= res_hi;
            resLO   <= res_lo;
            skip_wr <= is_div && div_zero;
            cnt     <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            Busy    <= 1'b1;
            state   <= RUN;
          end else if (!Start) begin
            if (MDUOp == OP_MTHI) HI <= SrcA;
            if (MDUOp == OP_MTLO) LO <= SrcA;
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            Busy  <= 1'b0;
            state <= IDLE;
            if (!skip_wr) begin
              HI <= resHI;
              LO <= resLO;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    MDUOut = '0;
    if (MDUOp == OP_MFHI) MDUOut = HI;
    else if (MDUOp == OP_MFLO) MDUOut = LO;
  end

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  int total = 0;
  int bad = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the architectural result.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    longint p;
    longint unsigned up;
    case (op)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd3: if (b != 0) begin
        p = sa / sb; m_lo = p[31:0];
        p = sa % sb; m_hi = p[31:0];
      end
      4'd4: if (b != 0) begin
        up = ua / ub; m_lo = up[31:0];
        up = ua % ub; m_hi = up[31:0];
      end
      default: ;
    endcase
  endtask

  function automatic int latency(input logic [3:0] op);
    return (op <= 4'd2) ? MC : DC;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op and count the cycles Busy stays high (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
    tick();
    Start = 1'b0; MDUOp = 4'd0;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; SrcA = '0; SrcB = '0;
    tick(); tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", LO); end
    total++; if (MDUOut !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", MDUOut); end
  endtask

  task automatic test_mult();
    int n;
    model_op(4'd1, 32'hFFFFFFFF, 32'd2);
    run_op(4'd1, 32'hFFFFFFFF, 32'd2, n);
    total++; if (n != MC) begin bad++; $display("FAIL mult_busy got=%0d exp=%0d", n, MC); end
    total++; if (HI !== 32'hFFFFFFFF || HI !== m_hi) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    total++; if (LO !== 32'hFFFFFFFE || LO !== m_lo) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", LO); end
    MDUOp = 4'd5; #1;
    total++; if (MDUOut !== 32'hFFFFFFFF) begin bad++; $display("FAIL mfhi got=%h exp=ffffffff", MDUOut); end
    MDUOp = 4'd6; #1;
    total++; if (MDUOut !== 32'hFFFFFFFE) begin bad++; $display("FAIL mflo got=%h exp=fffffffe", MDUOut); end
    MDUOp = 4'd0; #1;
    total++; if (MDUOut !== 32'h0) begin bad++; $display("FAIL out_none got=%h exp=0", MDUOut); end
    MDUOp = 4'd11; #1;
    total++; if (MDUOut !== 32'h0) begin bad++; $display("FAIL out_op11 got=%h exp=0", MDUOut); end
    // Undefined op with Start launches nothing
    Start = 1'b1; tick(); Start = 1'b0; MDUOp = 4'd0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL op11_nolaunch got=%b exp=0", Busy); end
  endtask

  task automatic test_multu();
    int n;
    model_op(4'd2, 32'hFFFFFFFF, 32'd2);
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, n);
    total++; if (n != MC) begin bad++; $display("FAIL multu_busy got=%0d exp=%0d", n, MC); end
    total++; if (HI !== 32'h00000001) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", HI); end
    total++; if (LO !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", LO); end
  endtask

  task automatic test_div();
    int n;
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    total++; if (n != DC) begin bad++; $display("FAIL div_busy got=%0d exp=%0d", n, DC); end
    total++; if (LO !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    total++; if (HI !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    run_op(4'd4, 32'd100, 32'd7, n);
    total++; if (n != DC) begin bad++; $display("FAIL divu_busy got=%0d exp=%0d", n, DC); end
    total++; if (LO !== 32'd14) begin bad++; $display("FAIL divu_lo got=%h exp=0000000e", LO); end
    total++; if (HI !== 32'd2) begin bad++; $display("FAIL divu_hi got=%h exp=00000002", HI); end
    model_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    total++; if (LO !== m_lo || HI !== m_hi) begin
      bad++; $display("FAIL div_ovf got=%h:%h exp=%h:%h", HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_divzero();
    int n;
    Start = 1'b0; MDUOp = 4'd7; SrcA = 32'h12345678;
    tick();
    m_hi = 32'h12345678;
    m_lo = LO;
    MDUOp = 4'd5; #1;
    total++; if (MDUOut !== 32'h12345678) begin bad++; $display("FAIL mthi_mfhi got=%h exp=12345678", MDUOut); end
    run_op(4'd4, 32'hDEADBEEF, 32'd0, n);
    total++; if (n != DC) begin bad++; $display("FAIL divz_busy got=%0d exp=%0d", n, DC); end
    total++; if (HI !== m_hi) begin bad++; $display("FAIL divz_hi got=%h exp=%h", HI, m_hi); end
    total++; if (LO !== m_lo) begin bad++; $display("FAIL divz_lo got=%h exp=%h", LO, m_lo); end
    // MTLO then MFLO
    MDUOp = 4'd8; SrcA = 32'hA5A5_0F0F;
    tick();
    m_lo = 32'hA5A5_0F0F;
    MDUOp = 4'd6; #1;
    total++; if (MDUOut !== m_lo) begin bad++; $display("FAIL mtlo_mflo got=%h exp=%h", MDUOut, m_lo); end
    MDUOp = 4'd0;
  endtask

  task automatic test_ignore_in_flight();
    model_op(4'd1, 32'h00012345, 32'hFFFF0003);
    Start = 1'b1; MDUOp = 4'd1; SrcA = 32'h00012345; SrcB = 32'hFFFF0003;
    tick();
    for (int c = 1; c <= MC; c++) begin
      total++; if (Busy !== 1'b1) begin bad++; $display("FAIL inflight_busy c=%0d got=%b exp=1", c, Busy); end
      if (c == 2) begin
        Start = 1'b1; MDUOp = 4'd2; SrcA = 32'h77777777; SrcB = 32'h99999999;
      end else if (c == 3) begin
        Start = 1'b0; MDUOp = 4'd8; SrcA = 32'hCAFEBABE;
      end else begin
        Start = 1'b0; MDUOp = 4'd0;
      end
      tick();
    end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL inflight_done got=%b exp=0", Busy); end
    total++; if (HI !== m_hi || LO !== m_lo) begin
      bad++; $display("FAIL inflight_res got=%h:%h exp=%h:%h", HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    model_op(4'd2, 32'h0000FFFF, 32'h00010001);
    run_op(4'd2, 32'h0000FFFF, 32'h00010001, n);
    model_op(4'd4, 32'hFFFFFFF0, 32'd3);
    run_op(4'd4, 32'hFFFFFFF0, 32'd3, n);
    total++; if (n != DC) begin bad++; $display("FAIL b2b_busy got=%0d exp=%0d", n, DC); end
    total++; if (HI !== m_hi || LO !== m_lo) begin
      bad++; $display("FAIL b2b_res got=%h:%h exp=%h:%h", HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_abort();
    Start = 1'b1; MDUOp = 4'd3; SrcA = 32'h0000_1000; SrcB = 32'd7;
    tick();
    Start = 1'b0; MDUOp = 4'd0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", Busy); end
    total++; if (HI !== 32'h0 || LO !== 32'h0) begin bad++; $display("FAIL abort_clr got=%h:%h exp=0:0", HI, LO); end
    for (int c = 0; c < DC + 2; c++) tick();
    total++; if (HI !== 32'h0 || LO !== 32'h0 || Busy !== 1'b0) begin
      bad++; $display("FAIL abort_nowrite got=%h:%h busy=%b exp=0:0 busy=0", HI, LO, Busy);
    end
  endtask

  task automatic test_random();
    int n;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) begin
        op = 4'($urandom_range(7, 8));
        Start = 1'b0; MDUOp = op; SrcA = a;
        tick();
        MDUOp = 4'd0;
        if (op == 4'd7) m_hi = a; else m_lo = a;
        total++; if (HI !== m_hi || LO !== m_lo) begin
          bad++; $display("FAIL rnd_mt i=%0d got=%h:%h exp=%h:%h", i, HI, LO, m_hi, m_lo);
        end
      end else begin
        op = 4'($urandom_range(1, 4));
        model_op(op, a, b);
        run_op(op, a, b, n);
        total++; if (n != latency(op)) begin
          bad++; $display("FAIL rnd_busy i=%0d op=%0d got=%0d exp=%0d", i, op, n, latency(op));
        end
        total++; if (HI !== m_hi || LO !== m_lo) begin
          bad++; $display("FAIL rnd_res i=%0d op=%0d a=%h b=%h got=%h:%h exp=%h:%h",
                          i, op, a, b, HI, LO, m_hi, m_lo);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_ignore_in_flight();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
